// File: rtl/ws281x_pkg.sv
// Shared types and defaults for the WS281x line encoder family.
package ws281x_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    RSTC
  } ws_state_t;

  localparam int WS_PRESCALE_DEF  = 2;
  localparam int WS_CNT_WIDTH_DEF = 8;
  localparam int WS_RST_WIDTH_DEF = 16;

  typedef logic [WS_CNT_WIDTH_DEF-1:0] ws_cnt_t;
  typedef logic [WS_RST_WIDTH_DEF-1:0] ws_rst_cnt_t;

endpackage

// File: rtl/ws281x_tick.sv
// Timing-unit prescaler: pulses tick_o once every PRESCALE clocks, restartable via clr_i.
module ws281x_tick
  import ws281x_pkg::*;
#(
  parameter int PRESCALE = WS_PRESCALE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    tick_o = (pre_q == PRE_LAST);
    pre_d  = pre_q + 1'b1;
    if (clr_i || tick_o) pre_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/ws281x_bit_enc.sv
// WS281x single-lane encoder: turns data-bit / reset-code symbols into the serial LED waveform.
module ws281x_bit_enc
  import ws281x_pkg::*;
#(
  parameter int CNT_WIDTH = WS_CNT_WIDTH_DEF,
  parameter int RST_WIDTH = WS_RST_WIDTH_DEF,
  parameter int PRESCALE  = WS_PRESCALE_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bit_vld_i,
  output logic                 bit_rdy_o,
  input  logic                 bit_data_i,
  input  logic                 bit_rst_i,
  input  logic [CNT_WIDTH-1:0] t0h_cnt_i,
  input  logic [CNT_WIDTH-1:0] t0s_cnt_i,
  input  logic [CNT_WIDTH-1:0] t1h_cnt_i,
  input  logic [CNT_WIDTH-1:0] t1s_cnt_i,
  input  logic [RST_WIDTH-1:0] trst_cnt_i,
  output logic [CNT_WIDTH-1:0] tim_cnt_o,
  output logic                 busy_o,
  output logic                 ws_o
);

  // Wide enough for th_eff+1 at full CNT_WIDTH and for the longest reset code.
  localparam int PW = (CNT_WIDTH + 1 > RST_WIDTH) ? CNT_WIDTH + 1 : RST_WIDTH;

  ws_state_t     state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [PW-1:0] th_q, th_d;
  logic [PW-1:0] len_q, len_d;
  logic          ws_q, ws_d;

  logic          tick;
  logic          accept;
  logic          last_unit;
  logic [PW-1:0] per_inc;
  logic [PW-1:0] th_sel, ts_sel;
  logic [PW-1:0] th_eff, ts_eff, trst_eff;

  ws281x_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .tick_o(tick)
  );

  always_comb begin
    th_sel   = bit_data_i ? PW'(t1h_cnt_i) : PW'(t0h_cnt_i);
    ts_sel   = bit_data_i ? PW'(t1s_cnt_i) : PW'(t0s_cnt_i);
    th_eff   = (th_sel == '0) ? PW'(1) : th_sel;
    ts_eff   = (ts_sel > th_eff) ? ts_sel : th_eff + PW'(1);
    trst_eff = (trst_cnt_i == '0) ? PW'(1) : PW'(trst_cnt_i);

    per_inc   = per_q + PW'(1);
    last_unit = tick && (per_inc == len_q);
    bit_rdy_o = (state_q == IDLE) ||
                (((state_q == LOW) || (state_q == RSTC)) && last_unit);
    accept    = bit_vld_i && bit_rdy_o;

    state_d = state_q;
    per_d   = per_q;
    th_d    = th_q;
    len_d   = len_q;

    if (tick && (state_q != IDLE)) per_d = per_inc;

    case (state_q)
      HIGH:      if (tick && (per_inc == th_q)) state_d = LOW;
      LOW, RSTC: if (last_unit) state_d = IDLE;
      default:   state_d = state_q;
    endcase

    // Acceptance overrides the end-of-symbol transition so back-to-back symbols have no gap.
    if (accept) begin
      per_d = '0;
      if (bit_rst_i) begin
        state_d = RSTC;
        th_d    = PW'(1);
        len_d   = trst_eff;
      end else begin
        state_d = HIGH;
        th_d    = th_eff;
        len_d   = ts_eff;
      end
    end

    ws_d = (state_d == HIGH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      per_q   <= '0;
      th_q    <= '0;
      len_q   <= '0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      th_q    <= th_d;
      len_q   <= len_d;
      ws_q    <= ws_d;
    end
  end

  assign ws_o      = ws_q;
  assign busy_o    = (state_q != IDLE);
  assign tim_cnt_o = ((state_q == HIGH) || (state_q == LOW)) ? len_q[CNT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_ws281x_bit_enc.sv
// Directed bench for ws281x_bit_enc: measures each symbol's high/low clocks against a scoreboard.
module tb_ws281x_bit_enc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        bit_vld_i;
  logic        bit_rdy_o;
  logic        bit_data_i;
  logic        bit_rst_i;
  logic [7:0]  t0h_cnt_i, t0s_cnt_i, t1h_cnt_i, t1s_cnt_i;
  logic [15:0] trst_cnt_i;
  logic [7:0]  tim_cnt_o;
  logic        busy_o;
  logic        ws_o;

  ws281x_bit_enc #(
    .CNT_WIDTH(8),
    .RST_WIDTH(16),
    .PRESCALE (2)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bit_vld_i (bit_vld_i),
    .bit_rdy_o (bit_rdy_o),
    .bit_data_i(bit_data_i),
    .bit_rst_i (bit_rst_i),
    .t0h_cnt_i (t0h_cnt_i),
    .t0s_cnt_i (t0s_cnt_i),
    .t1h_cnt_i (t1h_cnt_i),
    .t1s_cnt_i (t1s_cnt_i),
    .trst_cnt_i(trst_cnt_i),
    .tim_cnt_o (tim_cnt_o),
    .busy_o    (busy_o),
    .ws_o      (ws_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int hi;
    int lo;
    int tim;
    bit chk_gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  int n_assert = 0;
  int n_fail   = 0;

  bit active    = 1'b0;
  bit abort_req = 1'b0;
  int hi_cnt, lo_cnt, tim_obs, gap_cnt, gap_obs;
  int busy_bad;
  int idle_ws_bad = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Monitor: one symbol spans from the cycle after acceptance to the cycle where bit_rdy_o rises.
  always @(negedge clk_i) begin
    if (abort_req) begin
      active    = 1'b0;
      abort_req = 1'b0;
      gap_cnt   = 0;
    end else begin
      if (active) begin
        if (ws_o) hi_cnt++;
        else      lo_cnt++;
        if (!busy_o) busy_bad = 1;
        if (hi_cnt + lo_cnt == 1) tim_obs = int'(tim_cnt_o);
        if (bit_rdy_o) begin
          active  = 1'b0;
          gap_cnt = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_symbol", 1, 0);
          end else begin
            e_mon = exp_q.pop_front();
            check("high_clks", hi_cnt, e_mon.hi);
            check("low_clks", lo_cnt, e_mon.lo);
            check("tim_cnt", tim_obs, e_mon.tim);
            check("busy_in_symbol", busy_bad, 0);
            if (e_mon.chk_gap) check("gap_clks", gap_obs, 0);
          end
        end
      end else begin
        gap_cnt++;
        if (ws_o) idle_ws_bad++;
      end
      if (!rst_i && bit_vld_i && bit_rdy_o) begin
        active   = 1'b1;
        hi_cnt   = 0;
        lo_cnt   = 0;
        busy_bad = 0;
        gap_obs  = gap_cnt;
      end
    end
  end

  task automatic send(input bit r, input bit d, input int th, input int ts, input int trst,
                      input bit gap0, input bit push);
    exp_t e;
    int   n;
    int   th_e;
    int   ts_e;
    bit_vld_i  = 1'b1;
    bit_rst_i  = r;
    bit_data_i = d;
    t0h_cnt_i  = 8'd40;
    t0s_cnt_i  = 8'd50;
    t1h_cnt_i  = 8'd60;
    t1s_cnt_i  = 8'd70;
    trst_cnt_i = 16'd9;
    if (r)      trst_cnt_i = 16'(trst);
    else if (d) begin t1h_cnt_i = 8'(th); t1s_cnt_i = 8'(ts); end
    else        begin t0h_cnt_i = 8'(th); t0s_cnt_i = 8'(ts); end
    th_e = (th < 1) ? 1 : th;
    ts_e = (ts > th_e) ? ts : th_e + 1;
    if (r) e = '{0, ((trst < 1) ? 1 : trst) * 2, 0, gap0};
    else   e = '{th_e * 2, (ts_e - th_e) * 2, ts_e, gap0};
    if (push) exp_q.push_back(e);
    n = 0;
    @(negedge clk_i);
    while (!bit_rdy_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("accept_wait", int'(n >= 3000), 0);
    @(posedge clk_i);
    #1;
    // Timing inputs change mid-symbol; the latched values must be unaffected.
    bit_vld_i  = 1'b0;
    t0h_cnt_i  = 8'h11;
    t0s_cnt_i  = 8'h22;
    t1h_cnt_i  = 8'h03;
    t1s_cnt_i  = 8'h04;
    trst_cnt_i = 16'h0005;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((busy_o || exp_q.size() != 0) && n < 4000);
    check("wait_idle", int'(n >= 4000), 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i      = 1'b1;
    bit_vld_i  = 1'b0;
    bit_data_i = 1'b0;
    bit_rst_i  = 1'b0;
    t0h_cnt_i  = '0;
    t0s_cnt_i  = '0;
    t1h_cnt_i  = '0;
    t1s_cnt_i  = '0;
    trst_cnt_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ws", int'(ws_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_rdy", int'(bit_rdy_o), 1);
    check("reset_tim", int'(tim_cnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    send(0, 0, 1, 8'h80, 0, 0, 1);
    wait_idle();
    send(0, 1, 8'hfe, 8'hff, 0, 0, 1);
    wait_idle();

    // Back-to-back 1,0,1 with vld held across acceptances.
    send(0, 1, 3, 10, 0, 0, 1);
    send(0, 0, 2, 6, 0, 1, 1);
    send(0, 1, 4, 9, 0, 1, 1);
    wait_idle();

    send(0, 0, 0, 0, 0, 0, 1);
    wait_idle();
    send(0, 1, 5, 3, 0, 0, 1);
    wait_idle();

    send(1, 0, 0, 0, 16'h0190, 0, 1);
    wait_idle();
    check("idle_after_rstc_busy", int'(busy_o), 0);
    check("idle_after_rstc_rdy", int'(bit_rdy_o), 1);
    send(1, 1, 8, 20, 3, 0, 1);
    send(1, 0, 0, 0, 0, 1, 1);
    wait_idle();

    // Abort a long '1' bit mid-HIGH.
    send(0, 1, 8'hfe, 8'hff, 0, 0, 0);
    repeat (20) @(posedge clk_i);
    #1;
    rst_i     = 1'b1;
    abort_req = 1'b1;
    #1;
    check("abort_ws", int'(ws_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_rdy", int'(bit_rdy_o), 1);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    send(0, 1, 2, 4, 0, 0, 1);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    check("idle_ws_high", idle_ws_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
